lfsr_msg_encryptor: RTL and testbench

//  Hardware accelerator for Program #1, the encrypt direction of the LFSR message cipher.
//  - Reads the plaintext and config bytes from the data memory.
//  - Builds the 64-byte space-padded message and XORs each byte with a 7-bit LFSR state.
//  - Puts the parity bit in bit 7 and writes the ciphertext to mem[64..127].
//  - Its output is exactly the input image that the Program #2 decrypt bench/program consumes.

---
 rtl/lfsr_msg_encryptor_pkg.sv | 24 ++
 rtl/lfsr_msg_encryptor_lfsr7.sv | 18 +
 rtl/lfsr_msg_encryptor.sv | 95 +++++++++
 tb/tb_lfsr_msg_encryptor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_msg_encryptor_pkg.sv
// enc_pkg: state encoding, memory map and LFSR/parity helpers shared by the
// encrypt and decrypt sides of the LFSR message cipher.
package enc_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CFG0, S_CFG1, S_CFG2, S_CFG3, S_RD, S_WR, S_DONE
  } enc_state_t;

  localparam logic [7:0] MSG_BASE  = 8'd0;
  localparam logic [7:0] CFG_PRE   = 8'd61;
  localparam logic [7:0] CFG_TAP   = 8'd62;
  localparam logic [7:0] CFG_INIT  = 8'd63;
  localparam logic [7:0] OUT_BASE  = 8'd64;
  localparam int         NUM_BYTES = 64;
  localparam logic [6:0] MAX_MSG   = 7'd49;
  localparam logic [7:0] PAD_CHAR  = 8'h20;

  function automatic logic [6:0] lfsr7_next(input logic [6:0] s, input logic [6:0] taps);
    return {s[5:0], ^(s & taps)};
  endfunction

  function automatic logic ascii_parity(input logic [7:0] b);
    return ^b[6:0];
  endfunction
endpackage

// File: rtl/lfsr_msg_encryptor_lfsr7.sv
// lfsr7: 7-bit LFSR with programmable taps; load wins over step, else hold.
module lfsr7
  import enc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [6:0] i_init,
  input  logic [6:0] i_taps,
  output logic [6:0] o_state
);
  // an all-zero seed would lock the register at zero, so it becomes 1
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_state <= '0;
    else if (i_load) o_state <= (i_init == '0) ? 7'h01 : i_init;
    else if (i_step) o_state <= lfsr7_next(o_state, i_taps);
endmodule

// File: rtl/lfsr_msg_encryptor.sv
// lfsr_msg_encryptor: reads plaintext/config from data memory, pads to 64 bytes,
// XORs with a 7-bit LFSR, adds parity in bit 7 and writes ciphertext to 64..127.
module lfsr_msg_encryptor
  import enc_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data
);
  localparam logic [6:0] LAST_IDX = 7'(NUM_BYTES - 1);

  enc_state_t r_state;
  logic [6:0] r_idx;
  logic [3:0] r_pre;
  logic [6:0] r_taps;
  logic       r_pad;
  logic       r_ack;
  logic [6:0] w_lfsr;
  logic [6:0] w_off;
  logic       w_src_ok;
  logic [7:0] w_plain;
  logic [7:0] w_ct;

  assign w_off    = r_idx - {3'b0, r_pre};
  assign w_src_ok = (r_idx >= {3'b0, r_pre}) && (w_off < MAX_MSG);
  assign w_plain  = (r_pad || mem_rd_data == 8'h00) ? PAD_CHAR : mem_rd_data;
  assign w_ct     = {ascii_parity({1'b0, w_plain[6:0] ^ w_lfsr}), w_plain[6:0] ^ w_lfsr};

  // read data arrives one cycle after the address, so the bus is driven from state
  assign mem_addr = (r_state == S_CFG0)            ? CFG_PRE :
                    (r_state == S_CFG1)            ? CFG_TAP :
                    (r_state == S_CFG2)            ? CFG_INIT :
                    (r_state == S_RD && w_src_ok)  ? MSG_BASE + {1'b0, w_off} :
                    (r_state == S_WR)              ? OUT_BASE + {1'b0, r_idx} :
                                                     MSG_BASE;
  assign mem_wr_en   = (r_state == S_WR);
  assign mem_wr_data = mem_wr_en ? w_ct : '0;
  assign Ack         = r_ack;

  lfsr7 u_lfsr (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_load  (r_state == S_CFG3),
    .i_step  (r_state == S_WR),
    .i_init  (mem_rd_data[6:0]),
    .i_taps  (r_taps),
    .o_state (w_lfsr)
  );

  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pre   <= '0;
      r_taps  <= '0;
      r_pad   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (!Start) begin
          r_state <= S_CFG0;
          r_idx   <= '0;
        end
        S_CFG0: r_state <= S_CFG1;
        S_CFG1: begin
          r_pre   <= mem_rd_data[3:0];
          r_state <= S_CFG2;
        end
        S_CFG2: begin
          r_taps  <= mem_rd_data[6:0];
          r_state <= S_CFG3;
        end
        S_CFG3: r_state <= S_RD;
        S_RD: begin
          r_pad   <= !w_src_ok;
          r_state <= S_WR;
        end
        S_WR: begin
          r_idx   <= r_idx + 7'd1;
          r_state <= (r_idx == LAST_IDX) ? S_DONE : S_RD;
          r_ack   <= (r_idx == LAST_IDX);
        end
        S_DONE: if (Start) begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_lfsr_msg_encryptor.sv
// tb_lfsr_msg_encryptor: directed runs against a byte-level memory and a
// reference cipher model, plus hand-computed ciphertext bytes.
module tb_lfsr_msg_encryptor;
  logic       Clk = 0, Reset = 0, Start = 1;
  logic       Ack, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
  logic       ld_en = 0;
  logic [7:0] ld_addr = 0, ld_data = 0;
  logic [7:0] mem [256];
  logic [7:0] expv [64];
  logic [7:0] run1 [64];
  int checks = 0, errors = 0, wr_cnt = 0, over_rd = 0, bad_wr = 0;

  lfsr_msg_encryptor dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (mem_wr_en && mem_addr < 8'd64) bad_wr <= bad_wr + 1;
    if (!mem_wr_en && mem_addr >= 8'd49 && mem_addr <= 8'd60) over_rd <= over_rd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic setup(input string msg, input logic [7:0] pre, input logic [7:0] taps,
                       input logic [7:0] init, input logic [7:0] fill);
    @(negedge Clk);
    ld_en = 1;
    for (int a = 0; a < 128; a++) begin
      ld_addr = 8'(a);
      ld_data = (a < msg.len()) ? msg[a] : (a < 61) ? fill : (a == 61) ? pre :
                (a == 62) ? taps : (a == 63) ? init : 8'hEE;
      @(negedge Clk);
    end
    ld_en = 0;
  endtask

  task automatic model();
    logic [3:0] pre;
    logic [6:0] taps, s;
    logic [7:0] p, c;
    pre  = mem[61][3:0];
    taps = mem[62][6:0];
    s    = mem[63][6:0];
    if (s == 7'd0) s = 7'h01;
    for (int i = 0; i < 64; i++) begin
      p = 8'h20;
      if (i >= int'(pre) && i - int'(pre) < 49 && mem[i - int'(pre)] != 8'h00) p = mem[i - int'(pre)];
      c = p ^ {1'b0, s};
      c[7] = ^c[6:0];
      expv[i] = c;
      s = {s[5:0], ^(s & taps)};
    end
  endtask

  task automatic compare(input string tag);
    for (int i = 0; i < 64; i++) chk($sformatf("%s[%0d]", tag, 64 + i), mem[64 + i], expv[i]);
  endtask

  task automatic run(output int cyc);
    cyc = 0;
    @(negedge Clk) Start = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (!Ack && cyc < 400);
    Start = 1;
    @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, w0, o0;
    string alpha;
    alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvw";
    repeat (3) @(negedge Clk);
    chk("rst_ack", Ack, 0);
    chk("rst_wen", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wr_data, 0);
    @(negedge Clk) Reset = 1;

    setup("Mr. Watson, come here. I want to see you.", 8'd10, 8'h60, 8'h01, 8'h00);
    model();
    for (int i = 0; i < 64; i++) run1[i] = expv[i];
    w0 = wr_cnt;
    repeat (200) @(negedge Clk);
    chk("idle_wr", wr_cnt - w0, 0);
    chk("idle_ack", Ack, 0);
    run(cyc);
    chk("latency", cyc, 133);
    chk("ack_clr", Ack, 0);
    chk("t1_wcnt", wr_cnt - w0, 64);
    chk("t1_b64", mem[64], 8'h21);
    chk("t1_b65", mem[65], 8'h22);
    chk("t1_b66", mem[66], 8'h24);
    compare("t1");

    setup("Mr. Watson, come here. I want to see you.", 8'd10, 8'h60, 8'h00, 8'h00);
    for (int i = 0; i < 64; i++) expv[i] = run1[i];
    run(cyc);
    compare("t2");

    setup("", 8'd10, 8'h48, 8'h5A, 8'h00);
    model();
    run(cyc);
    chk("t3_b64", mem[64], 8'hFA);
    chk("t3_b65", mem[65], 8'h14);
    chk("t3_b66", mem[66], 8'h48);
    compare("t3");

    o0 = over_rd;
    setup(alpha, 8'd15, 8'h60, 8'h33, "Z");
    model();
    run(cyc);
    compare("t4a");
    setup(alpha, 8'd0, 8'h60, 8'h33, "Z");
    model();
    run(cyc);
    compare("t4b");
    chk("t4_ovr_rd", over_rd - o0, 0);

    setup("Mr. Watson, come here. I want to see you.", 8'd10, 8'h60, 8'h01, 8'h00);
    model();
    @(negedge Clk) Start = 0;
    repeat (50) @(negedge Clk);
    Reset = 0;
    #1;
    chk("abort_ack", Ack, 0);
    chk("abort_wen", mem_wr_en, 0);
    w0 = wr_cnt;
    Start = 1;
    repeat (5) @(negedge Clk);
    Reset = 1;
    repeat (150) @(negedge Clk);
    chk("abort_wr", wr_cnt - w0, 0);
    chk("abort_ack2", Ack, 0);
    chk("abort_tail", mem[127], 8'hEE);
    run(cyc);
    chk("t6_latency", cyc, 133);
    compare("t6");
    chk("bad_wr", bad_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
